// File: rtl/axis_conv_pkg.sv
// Shared helpers for the narrow-to-wide AXIS packer: geometry checks and page flag record.
package axis_conv_pkg;

  function automatic int calc_k(input int n, input int m);
    return (m > 0) ? n / m : 0;
  endfunction

  function automatic bit width_ok(input int n, input int m);
    return (m > 0) && (n % m == 0) && (n / m >= 2);
  endfunction

  function automatic int fill_width(input int k);
    return $clog2(k) + 1;
  endfunction

  typedef struct packed {
    logic first;
    logic valid;
  } page_flags_t;

endpackage

// File: rtl/axis_width_conv_narrow_wide.sv
// Packs M-bit symbols into N-bit words through a two-page ping-pong buffer.
// Optional macro AXIS_NW_PAD_EN: an early tfirst zero-pads and closes the page instead of discarding it.
module axis_width_conv_narrow_wide
  import axis_conv_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         s_axis_tnext,
  input  logic [M-1:0] s_axis_tdata,
  input  logic         s_axis_tfirst,
  input  logic         s_axis_tvalid,
  input  logic         m_axis_tnext,
  output logic [N-1:0] m_axis_tdata,
  output logic         m_axis_tfirst,
  output logic         m_axis_tvalid,
  output logic         short_word,
  output logic [15:0]  bit_count
);

  localparam int K = calc_k(N, M);
  localparam int W_FILL = fill_width(K);
  localparam logic [W_FILL-1:0] FILL_LAST = W_FILL'(K - 1);

  if (!width_ok(N, M)) begin : g_bad_width
    $error("axis_width_conv_narrow_wide: N must be a multiple of M with N/M >= 2");
  end

  typedef struct packed {
    logic [N-1:0] data;
    page_flags_t  flags;
  } page_t;

  typedef struct packed {
    page_t [1:0]       page;
    logic              wr_page;
    logic              rd_page;
    logic [W_FILL-1:0] fill;
    logic              short_word;
    logic [15:0]       bit_count;
  } regs_t;

  localparam regs_t REGS_RST = '0;

  regs_t             r;
  regs_t             r_n;
  logic              s_stall;
  logic              accept;
  logic              pad_close;
  logic              realign;
  logic              rd_take;
  logic [W_FILL-1:0] slot;
  logic [1:0]        nvalid;

  // Valid/ready contract: a symbol transfers on every cycle s_axis_tvalid is high and
  // s_axis_tnext is high; a word transfers on every cycle m_axis_tvalid and m_axis_tnext
  // are both high. s_axis_tnext never depends on m_axis_tnext.
  always_comb begin
    r_n            = r;
    r_n.short_word = 1'b0;
    s_stall        = r.page[r.wr_page].flags.valid;
    pad_close      = 1'b0;
    realign        = 1'b0;
    slot           = r.fill;
    nvalid         = 2'd0;

`ifdef AXIS_NW_PAD_EN
    // An early tfirst holds off input until the partial page can be closed behind a free page.
    if (s_axis_tvalid && s_axis_tfirst && (r.fill != '0)) begin
      s_stall   = 1'b1;
      pad_close = !r.page[~r.wr_page].flags.valid;
    end
`endif

    accept  = s_axis_tvalid && !s_stall;
    rd_take = m_axis_tnext && r.page[r.rd_page].flags.valid;

    if (rd_take) begin
      r_n.page[r.rd_page].flags.valid = 1'b0;
      r_n.rd_page                     = ~r.rd_page;
    end

    if (pad_close) begin
      for (int i = 0; i < K; i++) begin
        if (W_FILL'(i) >= r.fill) r_n.page[r.wr_page].data[N-1-i*M -: M] = '0;
      end
      r_n.page[r.wr_page].flags.valid = 1'b1;
      r_n.wr_page                     = ~r.wr_page;
      r_n.fill                        = '0;
      r_n.short_word                  = 1'b1;
    end else if (accept) begin
      // A tfirst mid-word drops the partial symbols and restarts the word at slot 0.
      realign = s_axis_tfirst && (r.fill != '0);
      slot    = realign ? '0 : r.fill;
      for (int i = 0; i < K; i++) begin
        if (W_FILL'(i) == slot) r_n.page[r.wr_page].data[N-1-i*M -: M] = s_axis_tdata;
      end
      if (slot == '0) r_n.page[r.wr_page].flags.first = s_axis_tfirst;
      if (slot == FILL_LAST) begin
        r_n.page[r.wr_page].flags.valid = 1'b1;
        r_n.wr_page                     = ~r.wr_page;
        r_n.fill                        = '0;
      end else begin
        r_n.fill = slot + W_FILL'(1);
      end
      if (realign) r_n.short_word = 1'b1;
    end

    nvalid        = {1'b0, r_n.page[0].flags.valid} + {1'b0, r_n.page[1].flags.valid};
    r_n.bit_count = 16'(nvalid) * 16'(N) + 16'(r_n.fill) * 16'(M);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r <= REGS_RST;
    else      r <= r_n;
  end

  assign s_axis_tnext  = accept;
  assign m_axis_tvalid = r.page[r.rd_page].flags.valid;
  assign m_axis_tdata  = r.page[r.rd_page].data;
  assign m_axis_tfirst = r.page[r.rd_page].flags.first;
  assign short_word    = r.short_word;
  assign bit_count     = r.bit_count;

endmodule
